// File: rtl/isa_pkg.sv
// ISA field layout, funtype/funcode names and the field-to-word encoder
// shared by the instruction loader.
package isa_pkg;

    typedef enum logic [1:0] {
        REG    = 2'b00,
        MEM    = 2'b01,
        BRANCH = 2'b10,
        KERNEL = 2'b11
    } funtype_t;

    typedef enum logic {
        W_IDLE  = 1'b0,
        W_WRITE = 1'b1
    } wr_state_t;

    localparam logic [1:0] FC_MOV = 2'b10;
    localparam logic [1:0] FC_CMP = 2'b11;

    localparam int TYPE_LSB   = 30;
    localparam int CODE_LSB   = 28;
    localparam int RD_LSB     = 24;
    localparam int RS_LSB     = 20;
    localparam int RX_LSB     = 16;
    localparam int IMMSEL_BIT = 0;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_IMM_RANGE = 2'b01;
    localparam logic [1:0] ERR_BR_IMM0   = 2'b10;

    typedef struct packed {
        logic [31:0] word;
        logic [1:0]  err;
    } enc_t;

    function automatic enc_t encode(
        input funtype_t    ftype,
        input logic [1:0]  fcode,
        input logic [3:0]  rd,
        input logic [3:0]  rs,
        input logic [3:0]  rx,
        input logic [27:0] imm,
        input logic        use_imm
    );
        enc_t r;
        r.word = '0;
        r.err  = ERR_NONE;
        r.word[TYPE_LSB +: 2] = ftype;
        r.word[CODE_LSB +: 2] = fcode;
        if (ftype == BRANCH) begin
            // bit 0 doubles as the decoder's immediate select, so it must be set
            r.word[27:0] = imm;
            if (!imm[IMMSEL_BIT]) r.err = ERR_BR_IMM0;
        end else begin
            r.word[RD_LSB +: 4]   = rd;
            r.word[RX_LSB +: 4]   = rx;
            r.word[IMMSEL_BIT]    = use_imm;
            if (use_imm) begin
                r.word[RS_LSB +: 4] = imm[3:0];
                if (imm[27:4] != '0) r.err = ERR_IMM_RANGE;
            end else if (!((ftype == REG && fcode == FC_MOV) || ftype == KERNEL)) begin
                r.word[RS_LSB +: 4] = rs;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; push and pop together when full
// is allowed and leaves the count unchanged.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !(rst || clr)) mem_q[wptr_q] <= wdata;
    end

    assign rdata = mem_q[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes instruction fields into 32-bit words, buffers them and streams
// them into instruction memory at consecutive addresses.
module instr_encoder_loader
    import isa_pkg::*;
#(
    parameter int                FIFO_DEPTH = 4,
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_funtype,
    input  logic [1:0]        req_funcode,
    input  logic [3:0]        req_rd,
    input  logic [3:0]        req_rs,
    input  logic [3:0]        req_rx,
    input  logic [27:0]       req_imm,
    input  logic              req_use_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic              busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    enc_t              enc;
    logic              accept;
    logic              enc_valid_q, enc_valid_d;
    logic [31:0]       enc_word_q, enc_word_d;
    logic              err_valid_q, err_valid_d;
    logic [1:0]        err_code_q, err_code_d;
    wr_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       fifo_rdata;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty, fifo_full;
    logic              pop_fire, fill_next;

    assign enc = encode(funtype_t'(req_funtype), req_funcode, req_rd, req_rs,
                        req_rx, req_imm, req_use_imm);

    assign req_ready = !flush && ((fifo_count + CW'(enc_valid_q)) < CW'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;

    // flush forces req_ready low, so accept==0 also empties the encode stage
    always_comb begin
        enc_valid_d = accept && (enc.err == ERR_NONE);
        enc_word_d  = accept ? enc.word : enc_word_q;
        err_valid_d = accept && (enc.err != ERR_NONE);
        err_code_d  = err_valid_d ? enc.err : err_code_q;
    end

    assign pop_fire  = (state_q == W_WRITE) && mem_ready && !flush;
    assign fill_next = enc_valid_q || (fifo_count > CW'(1)) ||
                       ((fifo_count == CW'(1)) && !pop_fire);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            W_IDLE: begin
                if (fill_next) state_d = W_WRITE;
            end
            W_WRITE: begin
                if (mem_ready) begin
                    addr_d = addr_q + 1'b1;
                    if (!fill_next) state_d = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
        if (flush) begin
            state_d = W_IDLE;
            addr_d  = BASE_ADDR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enc_valid_q <= 1'b0;
            enc_word_q  <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            state_q     <= W_IDLE;
            addr_q      <= BASE_ADDR;
        end else begin
            enc_valid_q <= enc_valid_d;
            enc_word_q  <= enc_word_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            state_q     <= state_d;
            addr_q      <= addr_d;
        end
    end

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (enc_valid_q),
        .wdata (enc_word_q),
        .pop   (pop_fire),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign mem_we    = (state_q == W_WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = mem_we ? fifo_rdata : '0;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign busy      = enc_valid_q || !fifo_empty || mem_we;

endmodule
